// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: two writeback ports onto one write port, plus a busy scoreboard.
// Optional conflict counter is built when RF_ARB_PERF_EN is defined; otherwise perf_conflicts reads 0.
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_data,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_data,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] chk_rs1,
    input  logic [ADDR_WIDTH-1:0] chk_rs2,
    output logic                  hazard,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [31:0]           perf_conflicts
);

    localparam int          NREG   = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WAIT_M = 4'(MAX_WAIT);

    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [NREG-1:0]       busy_q, busy_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic                  issue_acc;

    always_comb begin
        p1_ready = p1_valid & (~p0_valid | (wait_cnt_q == WAIT_M));
        p0_ready = p0_valid & ~p1_ready;
    end

    assign issue_ready = ~busy_q[issue_rd];
    assign hazard      = busy_q[chk_rs1] | busy_q[chk_rs2];
    assign issue_acc   = issue_valid & issue_ready & (issue_rd != '0);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!p1_valid || p1_ready) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_M) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // Clear before set: a same-register pair is excluded by issue_ready, so order only matters defensively.
    always_comb begin
        busy_d = busy_q;
        if (p1_ready) begin
            busy_d[p1_addr] = 1'b0;
        end
        if (issue_acc) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (p1_ready) begin
            rf_wen_d   = (p1_addr != '0);
            rf_waddr_d = p1_addr;
            rf_wdata_d = p1_data;
        end else if (p0_ready) begin
            rf_wen_d   = (p0_addr != '0);
            rf_waddr_d = p0_addr;
            rf_wdata_d = p0_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            busy_q     <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            busy_q     <= busy_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef RF_ARB_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (p0_valid && p1_valid) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_conflicts = perf_q;
`else
    assign perf_conflicts = '0;
`endif

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters:
  - port 0: in-order pipeline writeback (ALU/load), priority requester.
  - port 1: long-latency unit (multiply/divide), starvation-protected.
- Holds a per-register busy scoreboard for outstanding long-latency destinations and raises a decode hazard when a source register is pending.
- Sits between the writeback stage and the register file; drives the register file's wen/waddr/wdata.

Parameters:
ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH registers tracked.
DATA_WIDTH, 32, writeback data width.
MAX_WAIT, 3, consecutive denied cycles after which port 1 overrides port 0 (1..15).

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  reset, asynchronous, active-low.
p0_valid  input  1  pipeline writeback request.
p0_ready  output  1  grant to port 0, combinational.
p0_addr  input  ADDR_WIDTH  port 0 destination register.
p0_data  input  DATA_WIDTH  port 0 write data.
p1_valid  input  1  long-latency unit writeback request.
p1_ready  output  1  grant to port 1, combinational.
p1_addr  input  ADDR_WIDTH  port 1 destination register.
p1_data  input  DATA_WIDTH  port 1 write data.
issue_valid  input  1  long-latency op issuing with destination issue_rd.
issue_rd  input  ADDR_WIDTH  destination of issuing op.
issue_ready  output  1  combinational: busy[issue_rd]==0.
chk_rs1  input  ADDR_WIDTH  decode source 1.
chk_rs2  input  ADDR_WIDTH  decode source 2.
hazard  output  1  combinational: busy[chk_rs1] | busy[chk_rs2].
rf_wen  output  1  register-file write enable, registered.
rf_waddr  output  ADDR_WIDTH  register-file write address, registered.
rf_wdata  output  DATA_WIDTH  register-file write data, registered.
perf_conflicts  output  32  conflict counter (see Optional Feature).

Behaviour:
- Reset (rst low, async): rf_wen=0, rf_waddr=0, rf_wdata=0, all busy bits 0, wait_cnt=0, perf_conflicts=0. hazard/issue_ready reflect the cleared scoreboard immediately.
- Handshake: transfer on valid&ready. ready is never asserted without valid. At most one grant per cycle. Requester holds addr/data stable until granted.
- Grant:
  - p1 granted if p1_valid & (!p0_valid | wait_cnt==MAX_WAIT).
  - Otherwise p0 granted if p0_valid.
- wait_cnt:
  - +1 on cycles with p1_valid & !p1_ready, saturating at MAX_WAIT.
  - Cleared on p1 grant or when p1_valid is low.
- Output register: on a grant, next cycle rf_wen=1 and rf_waddr/rf_wdata = granted addr/data. With no grant, rf_wen=0; waddr/wdata hold their last values. Latency is exactly 1 cycle.
- x0: a grant with addr==0 completes the handshake but next-cycle rf_wen=0.
- Scoreboard:
  - issue accepted on issue_valid & issue_ready & issue_rd!=0 -> busy[issue_rd] set next edge.
  - issue_rd==0 is always accepted with no effect (issue_ready=1).
  - p1 grant clears busy[p1_addr] next edge.
  - Same-cycle issue to reg A and p1 clear of reg B: both take effect.
  - Same-register issue and clear cannot both occur, since issue_ready=0 while A is busy.
- p0 grants never touch the scoreboard.
- hazard uses current busy bits only. A register cleared this edge becomes non-hazard the cycle rf_wen writes it, so no forwarding is needed.
- busy[0] is constantly 0.

Optional Feature:
- Macro RF_ARB_PERF_EN.
- Defined: perf_conflicts is a 32-bit wrapping counter, +1 each cycle with p0_valid & p1_valid.
- Undefined: the counter logic is absent and perf_conflicts is tied to 0.

Test Plan:
- Reset: drive rst low mid-write (rf_wen=1) -> rf_wen=0, hazard=0, perf_conflicts=0 immediately, without waiting for a clock edge.
- Single writes: p0 write x5=0xDEADBEEF -> p0_ready same cycle, next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF. Then p0 write x0=0x1234 -> handshake completes, rf_wen=0.
- Starvation override: p0 and p1 valid every cycle, MAX_WAIT=3 -> p0 granted 3 cycles, p1 granted cycle 4, p0 resumes cycle 5. With RF_ARB_PERF_EN, perf_conflicts=5 after 5 cycles.
- Scoreboard set/clear: issue_rd=7 -> next cycle chk_rs1=7 gives hazard=1 and issue_rd=7 gives issue_ready=0. p1 write x7=0x55 -> hazard drops one edge later, the same cycle rf_wen writes x7.
- Simultaneous events: issue x9 and p1 clear x7 in the same cycle -> busy[9]=1 and busy[7]=0 next cycle. Issue x0 -> issue_ready=1, no hazard on chk_rs2=0.
- Macro off: rebuild without RF_ARB_PERF_EN, rerun the starvation test -> perf_conflicts stays 0 and grants are identical.
